button_debounce: RTL and testbench
==================================

# button_debounce

Input-side counterpart of the LED driver: samples a raw, asynchronous, bouncing pushbutton pin and produces a clean debounced level plus single-cycle press, release, short-press and long-press event pulses. Sits between the board button pad and the fabric logic. For example, it lets the LED blink logic be started, stopped or mode-switched by a user.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz); legal range is 2 or more.
- LONG_CYCLES, 25000000: cycles the button stays held after press acceptance before long_pulse fires; must be greater than DEBOUNCE_CYCLES.
- clk  input  1  single system clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- btn_in  input  1  raw pin, active-high = pressed, asynchronous to clk.
- btn_level  output  1  debounced level.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- short_pulse  output  1  one-cycle pulse, coincident with release_pulse, only if long_pulse did not fire during that press.
- long_pulse  output  1  one-cycle pulse, at most once per press.

## Operation
- Synchronizer: two-flop chain on btn_in produces sync; FSM sees only sync.
- Debounce counter deb_cnt: width $clog2(DEBOUNCE_CYCLES).
- Hold counter hold_cnt: width $clog2(LONG_CYCLES); saturating. Flag long_fired.
- FSM states:
  - IDLE: btn_level=0. If sync=1, go to PRESS_WAIT with deb_cnt=0.
  - PRESS_WAIT: if sync=0, go to IDLE (glitch rejected, no output). Else if deb_cnt==DEBOUNCE_CYCLES-1, go to HELD, assert press_pulse, set btn_level=1, clear hold_cnt and long_fired. Else increment deb_cnt.
  - HELD: increment hold_cnt. When hold_cnt==LONG_CYCLES-1 and !long_fired, assert long_pulse and set long_fired. If sync=0, go to RELEASE_WAIT with deb_cnt=0.
  - RELEASE_WAIT: hold_cnt frozen. If sync=1, return to HELD (bounce; no event, hold_cnt resumes). Else if deb_cnt==DEBOUNCE_CYCLES-1, go to IDLE, set btn_level=0, assert release_pulse, and assert short_pulse if !long_fired. Else increment deb_cnt.
- All outputs are registered; every pulse is exactly one cycle wide.
- Simultaneous cases:
  - If long_pulse and the HELD-to-RELEASE_WAIT transition occur in the same cycle, long_pulse still fires and short_pulse is suppressed.
  - hold_cnt never wraps; it stays at LONG_CYCLES-1.

## Timing
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; synchronizer flops, counters and long_fired clear; all five outputs are 0. Reset mid-press discards the press; no release_pulse is emitted.
- Press latency: btn_in sampled high at edge 0 with no further bounce gives press_pulse high after edge DEBOUNCE_CYCLES+2.
- Release latency: identical, DEBOUNCE_CYCLES+2 edges from the first low sample.
- long_pulse: asserted LONG_CYCLES cycles after press_pulse, plus any cycles spent in RELEASE_WAIT bounces.
- Minimum accepted press or release width: DEBOUNCE_CYCLES+1 stable synchronized cycles.

## Structure
- Shared package btn_pkg holds:
  - the 2-bit FSM state encodings: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3;
  - default timing constants, reused by future GPIO input blocks.
- One sub-module, sync_2ff: a generic two-flop synchronizer with asynchronous active-low reset. button_debounce instantiates it for btn_in.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- Reset with btn_in=1 held: all outputs 0 during reset. After rst_n rises, press_pulse occurs 6 edges later and btn_level becomes 1.
- Clean press, held 10 cycles, then clean release: press_pulse 6 edges after rise; release_pulse and short_pulse together 6 edges after fall; btn_level high in between; long_pulse never asserts.
- Glitch, btn_in high for 3 cycles only: no pulses; btn_level stays 0; FSM returns to IDLE.
- Hold 30 cycles: long_pulse exactly once, 20 cycles after press_pulse; release_pulse on release with short_pulse=0.
- Release bounce (low 2 cycles, high 1 cycle, then low steady): no event during the bounce; exactly one release_pulse, 6 edges after the final fall.
- rst_n pulsed low while in HELD: outputs drop to 0 immediately, no release_pulse. With btn_in still high, a fresh press_pulse follows 6 edges after rst_n rises.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for GPIO input blocks: debounce FSM encodings and
// default timing for a 25 MHz system clock.
package btn_pkg;

  // Debounce FSM state encodings
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // 10 ms debounce window and 1 s long-press threshold at 25 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_LONG_CYCLES     = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous inputs into clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; the first stage may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: clean level plus press/release/short/long event pulses.
// All outputs are registered; pulses are one cycle wide.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic          sync;
  logic [1:0]    state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_fired;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (sync)
  );

  // Debounce FSM with hold timer; pulses default low and are set for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_fired    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            hold_cnt    <= '0;
            long_fired  <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          // Saturate at the threshold so a very long hold never re-arms
          if (hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST && !long_fired) begin
            long_pulse <= 1'b1;
            long_fired <= 1'b1;
          end
          if (!sync) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // hold_cnt is frozen here; a bounce back high resumes it
          if (sync) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            short_pulse   <= !long_fired;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Expected pulse events are queued with their edge number when stimulus is
// driven; a monitor pops and compares whenever any pulse appears.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 2;  // edges from first sample to registered pulse

  // Event code bits: {press, release, short, long}
  localparam logic [3:0] EV_PRESS   = 4'b1000;
  localparam logic [3:0] EV_REL     = 4'b0100;
  localparam logic [3:0] EV_REL_SH  = 4'b0110;
  localparam logic [3:0] EV_LONG    = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse;

  int   checks   = 0;
  int   failures = 0;
  int   ecount   = 0;
  ev_t  exq[$];

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive btn_in at a negedge; the next posedge is the first sampling edge
  task automatic drive(input logic v);
    btn_in = v;
  endtask

  task automatic expect_ev(input int after_edges, input logic [3:0] ev);
    ev_t e;
    e.cyc = ecount + 1 + after_edges;
    e.ev  = ev;
    exq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sample just after each edge and match any pulse to the queue head
  always @(posedge clk) begin
    logic [3:0] obs;
    ev_t        e;
    #1;
    obs = {press_pulse, release_pulse, short_pulse, long_pulse};
    if (obs != 4'b0000) begin
      if (exq.size() == 0) begin
        chk("unexpected_pulse", {28'd0, obs}, 32'd0);
      end else begin
        e = exq.pop_front();
        chk("event_cycle", ecount, e.cyc);
        chk("event_kind", {28'd0, obs}, {28'd0, e.ev});
      end
    end
  end

  initial begin
    // Reset with the button already held
    rst_n  = 1'b0;
    btn_in = 1'b1;
    wait_cyc(3);
    chk("reset_outputs", {27'd0, btn_level, press_pulse, release_pulse, short_pulse, long_pulse}, 32'd0);
    rst_n = 1'b1;
    expect_ev(LAT, EV_PRESS);
    wait_cyc(10);
    chk("level_after_reset_press", btn_level, 1);
    drive(1'b0);
    expect_ev(LAT, EV_REL_SH);
    wait_cyc(10);
    chk("level_after_release1", btn_level, 0);

    // Clean press held 10 cycles then clean release
    drive(1'b1);
    expect_ev(LAT, EV_PRESS);
    wait_cyc(3);
    chk("level_before_accept", btn_level, 0);
    wait_cyc(7);
    chk("level_held", btn_level, 1);
    drive(1'b0);
    expect_ev(LAT, EV_REL_SH);
    wait_cyc(3);
    chk("level_during_release_wait", btn_level, 1);
    wait_cyc(7);
    chk("level_after_release2", btn_level, 0);

    // Three-cycle glitch is rejected
    drive(1'b1);
    wait_cyc(3);
    drive(1'b0);
    wait_cyc(4);
    chk("level_glitch", btn_level, 0);
    wait_cyc(6);

    // Long hold: long_pulse 20 after press, release without short
    drive(1'b1);
    expect_ev(LAT, EV_PRESS);
    expect_ev(LAT + LONG, EV_LONG);
    wait_cyc(30);
    drive(1'b0);
    expect_ev(LAT, EV_REL);
    wait_cyc(10);
    chk("level_after_long", btn_level, 0);

    // Release bounce: low 2, high 1, then steady low
    drive(1'b1);
    expect_ev(LAT, EV_PRESS);
    wait_cyc(14);
    drive(1'b0);
    wait_cyc(2);
    drive(1'b1);
    wait_cyc(1);
    drive(1'b0);
    expect_ev(LAT, EV_REL_SH);
    wait_cyc(3);
    chk("level_during_bounce", btn_level, 1);
    wait_cyc(7);
    chk("level_after_bounce", btn_level, 0);

    // Reset while held: immediate drop, no release, fresh press afterwards
    drive(1'b1);
    expect_ev(LAT, EV_PRESS);
    wait_cyc(10);
    chk("level_before_midreset", btn_level, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {27'd0, btn_level, press_pulse, release_pulse, short_pulse, long_pulse}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    expect_ev(LAT, EV_PRESS);
    wait_cyc(10);
    chk("level_after_midreset_press", btn_level, 1);
    drive(1'b0);
    expect_ev(LAT, EV_REL_SH);
    wait_cyc(10);
    chk("level_final", btn_level, 0);

    chk("queue_drained", 32'(exq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
